// File: rtl/servo_pwm_decoder_if.sv
// Result bundle of the servo PWM decoder.
// master drives the frame results, slave consumes them.
interface servo_pwm_decoder_if;
    logic [7:0] width;
    logic [8:0] period;
    logic       frame_valid;
    logic       err_width;
    logic       err_period;
    logic       locked;
    logic       signal_lost;
    logic [4:0] position;

    modport master (
        output width, period, frame_valid,
        output err_width, err_period,
        output locked, signal_lost, position
    );

    modport slave (
        input width, period, frame_valid,
        input err_width, err_period,
        input locked, signal_lost, position
    );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures high width and rise-to-rise period per frame.
// Optional SERVO_DEC_POSITION_EN decodes position = width - MIN_HIGH.
module servo_pwm_decoder #(
    parameter int FRAME_CYCLES = 200,
    parameter int PERIOD_TOL   = 4,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    servo_pwm_decoder_if.master bus
);

    localparam logic [8:0] P_LO  = 9'(FRAME_CYCLES - PERIOD_TOL);
    localparam logic [8:0] P_HI  = 9'(FRAME_CYCLES + PERIOD_TOL);
    localparam logic [8:0] P_TMO = 9'(2 * FRAME_CYCLES);
    localparam logic [7:0] H_LO  = 8'(MIN_HIGH);
    localparam logic [7:0] H_HI  = 8'(MAX_HIGH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t     state;
    logic       s1, s2, s3;
    logic [7:0] hcnt;
    logic [8:0] pcnt;
    logic [7:0] width_q;
    logic [8:0] period_q;
    logic       fv_q, ew_q, ep_q;
    logic       lock_q, lost_q;

    logic       rise, fall, tmo, close;
    logic       bad_w, bad_p;
    logic [7:0] hcnt_inc;
    logic [8:0] pcnt_inc;

    always_comb begin
        rise     = s2 & ~s3;
        fall     = ~s2 & s3;
        tmo      = (pcnt >= P_TMO);
        close    = (state == LOW) && rise;
        bad_w    = (hcnt < H_LO) || (hcnt > H_HI);
        bad_p    = (pcnt < P_LO) || (pcnt > P_HI);
        hcnt_inc = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
        pcnt_inc = (pcnt == 9'h1FF) ? pcnt : pcnt + 9'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            hcnt     <= '0;
            pcnt     <= '0;
            width_q  <= '0;
            period_q <= '0;
            fv_q     <= 1'b0;
            ew_q     <= 1'b0;
            ep_q     <= 1'b0;
            lock_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            s3   <= s2;
            fv_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= 8'd1;
                        pcnt  <= 9'd1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        pcnt  <= pcnt_inc;
                    end else if (tmo) begin
                        state  <= IDLE;
                        lost_q <= 1'b1;
                        lock_q <= 1'b0;
                    end else begin
                        hcnt <= hcnt_inc;
                        pcnt <= pcnt_inc;
                    end
                end
                LOW: begin
                    // A rise on the timeout edge still closes the frame.
                    if (rise) begin
                        state    <= HIGH;
                        width_q  <= hcnt;
                        period_q <= pcnt;
                        ew_q     <= bad_w;
                        ep_q     <= bad_p;
                        lock_q   <= ~(bad_w | bad_p);
                        lost_q   <= 1'b0;
                        fv_q     <= 1'b1;
                        hcnt     <= 8'd1;
                        pcnt     <= 9'd1;
                    end else if (tmo) begin
                        state  <= IDLE;
                        lost_q <= 1'b1;
                        lock_q <= 1'b0;
                    end else begin
                        pcnt <= pcnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERVO_DEC_POSITION_EN
    logic [4:0] pos_q;
    logic [7:0] pos_full;

    assign pos_full = hcnt - H_LO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q <= '0;
        end else if (close && !bad_w && !bad_p) begin
            pos_q <= pos_full[4:0];
        end
    end

    assign bus.position = pos_q;
`else
    assign bus.position = 5'd0;
`endif

    assign bus.width       = width_q;
    assign bus.period      = period_q;
    assign bus.frame_valid = fv_q;
    assign bus.err_width   = ew_q;
    assign bus.err_period  = ep_q;
    assign bus.locked      = lock_q;
    assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder.
// Expected values are hand-computed from frame timing.
module tb_servo_pwm_decoder;

`ifdef SERVO_DEC_POSITION_EN
    localparam bit POS_EN = 1'b1;
`else
    localparam bit POS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pwm_in = 1'b0;

    servo_pwm_decoder_if bus ();

    servo_pwm_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int drv_cyc = 0;
    int stb_cyc = 0;
    int n_stb = 0;
    int stb0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            n_stb   = n_stb + 1;
            stb_cyc = cyc;
        end
    end

    function automatic int epos(input int v);
        return POS_EN ? v : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int h, input int p);
        @(negedge clk);
        pwm_in  = 1'b1;
        drv_cyc = cyc;
        for (int i = 1; i < h; i++) @(negedge clk);
        @(negedge clk);
        pwm_in = 1'b0;
        for (int i = h + 1; i < p; i++) @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input int w, input int p,
                             input int ew, input int ep, input int pos);
        chk({tag, ".width"}, 32'(bus.width), 32'(w));
        chk({tag, ".period"}, 32'(bus.period), 32'(p));
        chk({tag, ".err_w"}, 32'(bus.err_width), 32'(ew));
        chk({tag, ".err_p"}, 32'(bus.err_period), 32'(ep));
        chk({tag, ".locked"}, 32'(bus.locked), 32'((ew | ep) == 0));
        chk({tag, ".lost"}, 32'(bus.signal_lost), 32'd0);
        chk({tag, ".pos"}, 32'(bus.position), 32'(epos(pos)));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".width"}, 32'(bus.width), 32'd0);
        chk({tag, ".period"}, 32'(bus.period), 32'd0);
        chk({tag, ".fv"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, ".err_w"}, 32'(bus.err_width), 32'd0);
        chk({tag, ".err_p"}, 32'(bus.err_period), 32'd0);
        chk({tag, ".locked"}, 32'(bus.locked), 32'd0);
        chk({tag, ".lost"}, 32'(bus.signal_lost), 32'd0);
        chk({tag, ".pos"}, 32'(bus.position), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        pulse(5, 200);
        chk("first_rise.nostb", 32'(n_stb), 32'd0);
        pulse(5, 200);
        chk("f5.count", 32'(n_stb), 32'd1);
        chk_frame("f5", 5, 200, 0, 0, 0);
        chk("f5.lat", 32'(stb_cyc - drv_cyc), 32'd3);

        pulse(17, 200);
        chk("f5b.count", 32'(n_stb), 32'd2);
        pulse(30, 200);
        chk_frame("f17", 17, 200, 0, 0, 12);
        chk("f17.lat", 32'(stb_cyc - drv_cyc), 32'd3);

        pulse(11, 200);
        chk_frame("f30", 30, 200, 1, 0, 12);
        pulse(10, 150);
        chk_frame("f11", 11, 200, 0, 0, 6);
        pulse(5, 200);
        chk_frame("p150", 10, 150, 0, 1, 6);

        stb0 = n_stb;
        repeat (250) @(negedge clk);
        chk("tmo.lost", 32'(bus.signal_lost), 32'd1);
        chk("tmo.locked", 32'(bus.locked), 32'd0);
        chk("tmo.nostb", 32'(n_stb), 32'(stb0));
        chk("tmo.width", 32'(bus.width), 32'd10);
        chk("tmo.period", 32'(bus.period), 32'd150);

        pulse(8, 200);
        chk("relock1.nostb", 32'(n_stb), 32'(stb0));
        chk("relock1.lost", 32'(bus.signal_lost), 32'd1);
        pulse(8, 200);
        chk("relock2.count", 32'(n_stb), 32'(stb0 + 1));
        chk_frame("f8", 8, 200, 0, 0, 3);

        @(negedge clk);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        stb0 = n_stb;
        pulse(6, 200);
        chk("postrst.nostb", 32'(n_stb), 32'(stb0));
        pulse(6, 200);
        chk("postrst.count", 32'(n_stb), 32'(stb0 + 1));
        chk_frame("f6", 6, 200, 0, 0, 1);

        pulse(1, 200);
        pulse(5, 200);
        chk_frame("w1", 1, 200, 1, 0, 1);
        pulse(5, 204);
        pulse(5, 205);
        chk_frame("p204", 5, 204, 0, 0, 0);
        pulse(5, 200);
        chk_frame("p205", 5, 205, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart to the servo PWM generator. Samples a servo PWM line (10 kHz clock, 200-cycle/20 ms frames, 5–25-cycle high pulses) and measures the high width and frame period of each complete frame. Reports each result with a one-cycle strobe, range and period error flags, and a lock/loss indication. Used to loop back and check the servo output, or to accept external servo commands.

## Interface
- `FRAME_CYCLES`, default 200: nominal frame period in clk cycles.
- `PERIOD_TOL`, default 4: allowed deviation of the period from `FRAME_CYCLES`, ± cycles.
- `MIN_HIGH`, default 5: minimum legal high width in cycles.
- `MAX_HIGH`, default 25: maximum legal high width in cycles.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  asynchronous servo PWM input.
- `width`  out  8  high width of the last completed frame, in cycles; saturates at 255.
- `period`  out  9  rise-to-rise period of the last completed frame; saturates at 511.
- `frame_valid`  out  1  one-cycle strobe when `width`/`period`/error flags update.
- `err_width`  out  1  last frame width was outside [`MIN_HIGH`, `MAX_HIGH`].
- `err_period`  out  1  last frame period was outside `FRAME_CYCLES` ± `PERIOD_TOL`.
- `locked`  out  1  last completed frame had no errors.
- `signal_lost`  out  1  timeout occurred; cleared by the next completed frame.
- `position`  out  5  decoded position; see Configuration.

## Operation
- **Input path**
  - `pwm_in` passes through a 2-FF synchronizer (`s1`, `s2`), then a delay stage `s3`.
  - rise = `s2 & ~s3`; fall = `~s2 & s3`.
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE → HIGH on rise. `hcnt` = 1, `pcnt` = 1. No output for this edge.
  - HIGH: `hcnt` and `pcnt` increment each cycle. On fall → LOW; `pcnt` increments.
  - LOW: `pcnt` increments. On rise, close the frame:
    - load `width` = `hcnt`, `period` = `pcnt`;
    - evaluate errors, pulse `frame_valid`;
    - restart with `hcnt` = 1, `pcnt` = 1, then → HIGH.
- **Timeout:** in HIGH or LOW, if `pcnt` reaches 2×`FRAME_CYCLES` (400):
  - `signal_lost` = 1, `locked` = 0, go to IDLE;
  - no `frame_valid`; `width` and `period` hold their values.
- **Counters:** 8-bit and 9-bit, saturating; they never wrap.
- **Flags:**
  - `err_width` and `err_period` are registered together with `frame_valid`;
  - `locked` = ~(`err_width` | `err_period`) from the same frame;
  - `signal_lost` clears on any completed frame.
- **Reset** (asynchronous, any time, including mid-frame): FSM to IDLE; synchronizer and counters to 0. Output reset values:
  - `width` 0, `period` 0, `frame_valid` 0;
  - `err_width` 0, `err_period` 0, `locked` 0, `signal_lost` 0, `position` 0.
  - After reset release, the first rise only starts a frame.

## Timing
- `pwm_in` rising, first sampled high at clk edge k: rise is seen at edge k+2.
  - Frame-closing outputs are registered at edge k+2.
  - `frame_valid` is high for exactly the cycle after edge k+2 (3-edge latency).
- `width` equals the number of clk edges at which `pwm_in` was sampled high.
- `period` equals the number of edges between successive sampled rises.
- A pulse one cycle wide is detected (`width` = 1, `err_width` = 1). There is no glitch filter.
- A rise and a timeout on the same edge: the rise wins (the frame closes normally).
- Back-to-back frames: the strobe is guaranteed once per frame; the minimum period is 2 cycles.

## Configuration
- **`SERVO_DEC_POSITION_EN` defined:**
  - on each error-free frame, `position` = `width` − `MIN_HIGH` (range 0–20), registered with `frame_valid`;
  - on error frames and on timeout, `position` holds its value.
- **Not defined:** `position` is tied to 0 and the subtract/hold logic is absent. All other behaviour is identical.

## Test plan
- Reset, then 200-cycle frames with 5-cycle high → `frame_valid` each frame, `width` = 5, `period` = 200, `locked` = 1, `position` = 0.
- Change the high time to 17 cycles → next frame gives `width` = 17, no errors, `position` = 12; strobe 3 edges after the closing `pwm_in` rise.
- 30-cycle high, 200 period → `err_width` = 1, `locked` = 0, `position` holds 12; a following 11-cycle frame → `locked` = 1, `position` = 6.
- Period 150 with a 10-cycle high → `period` = 150, `err_period` = 1, `err_width` = 0.
- `pwm_in` held low for 400 cycles after a frame → `signal_lost` = 1, `locked` = 0, no strobe. The next two rises restore `frame_valid` and clear `signal_lost`.
- Assert `rst` mid-HIGH → all outputs 0 immediately. After release, the first rise produces no strobe and the second rise does.
